// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, default tap masks/seeds and the feedback helper
// for the parametrised Fibonacci LFSR generator.
package lfsr_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } lfsr_state_t;

    localparam logic [4:0]  LFSR_TAPS_5  = 5'b10100;
    localparam logic [4:0]  LFSR_SEED_5  = 5'b00010;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [7:0]  LFSR_SEED_8  = 8'h01;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [15:0] LFSR_SEED_16 = 16'h0001;

    // Widths up to 32 fit; callers zero-extend state and mask.
    function automatic logic lfsr_fb(
        input logic [31:0] q,
        input logic [31:0] taps
    );
        return ^(q & taps);
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR with step enable, seed load, zero-seed
// substitution and a period counter that pulses on every full wrap.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int                 WIDTH = 5,
    parameter logic [WIDTH-1:0]   TAPS  = LFSR_TAPS_5,
    parameter logic [WIDTH-1:0]   SEED  = LFSR_SEED_5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_seed,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             valid,
    output logic             wrap,
    output logic             lockup
);

    // Count value at which the next step completes 2^WIDTH-1 steps.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_gen: TAPS MSB must be set");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be non-zero");
    end

    lfsr_state_t      state;
    lfsr_state_t      state_next;
    logic             do_load;
    logic             do_step;
    logic             seed_zero;
    logic             fb;
    logic [WIDTH-1:0] cnt;

    assign seed_zero = (load_seed == '0);
    assign fb        = lfsr_fb(32'(q), 32'(TAPS));
    assign bit_out   = q[WIDTH-1];

    // State register: reset parks the FSM in INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: INIT always leaves after one cycle; load forces RUN.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = RUN;
        end else begin
            unique case (state)
                INIT:    state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = INIT;
            endcase
        end
    end

    // Per-state actions: load wins over en; stepping only in RUN.
    always_comb begin
        do_load = load;
        do_step = 1'b0;
        unique case (state)
            INIT:    do_step = 1'b0;
            RUN:     do_step = en && !load;
            default: do_step = 1'b0;
        endcase
    end

    // Shift register, period counter and the registered status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= SEED;
            cnt    <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end else begin
            valid  <= (state_next == RUN);
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (do_load) begin
                q      <= seed_zero ? SEED : load_seed;
                cnt    <= '0;
                lockup <= seed_zero;
            end else if (do_step) begin
                q <= {q[WIDTH-2:0], fb};
                if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    wrap <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random source for the lab5 datapath. It replaces the fixed 5-bit generator and adds the following:
- configurable width, tap mask and reset seed;
- step enable;
- run-time seed load with zero-seed protection;
- a period counter that flags each full sequence wrap.

It feeds noise/modulation consumers that sample `q` or the serial `bit_out` once per enabled step.

## Interface
Parameters:
- `WIDTH`, 5: register width, 3..32.
- `TAPS`, 5'b10100: feedback mask. `TAPS[WIDTH-1]` must be 1; elaboration assertion.
- `SEED`, 5'b00010: reset and substitute seed. Must be non-zero; elaboration assertion.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  advance one step this cycle.
- `load`  in  1  load `load_seed` this cycle.
- `load_seed`  in  WIDTH  seed value.
- `q`  out  WIDTH  current LFSR state.
- `bit_out`  out  1  `q[WIDTH-1]`.
- `valid`  out  1  generator running; `q` is meaningful.
- `wrap`  out  1  one-cycle pulse, `2^WIDTH-1` steps completed since last reset/load.
- `lockup`  out  1  one-cycle pulse, zero seed rejected.

## Operation
- Step: `fb = ^(q & TAPS)`; `q_next = {q[WIDTH-2:0], fb}`.
- FSM, two states:
  - `INIT`: entered on reset. Holds `q`. Moves to `RUN` on the next clock unconditionally.
  - `RUN`: steps on `en`.
- Priority each cycle: `reset` > `load` > `en`.
- Load:
  - Accepted in any state; next state is `RUN`.
  - `q <= load_seed`, step counter cleared.
  - If `load_seed == 0`: `q <= SEED` instead, and `lockup` pulses next cycle.
- `en` in `INIT` is ignored; no step occurs.
- `load` and `en` in the same cycle: load only, no step.
- Step counter `cnt`:
  - WIDTH bits; increments on each `RUN` step.
  - At a step with `cnt == 2^WIDTH-2`: `cnt <= 0` and `wrap <= 1` for one cycle.
  - `wrap` is coincident with the `q` value that completes the period. For primitive `TAPS`, that value equals the seed.
- Non-primitive `TAPS` are legal; `wrap` still fires every `2^WIDTH-1` steps, regardless of the actual sequence period.
- `q` never reaches zero from a non-zero state, given `TAPS[WIDTH-1] = 1`. No runtime zero check is needed beyond the load path.

## Timing
- All outputs are registered.
- Reset values:
  - `q = SEED`
  - `bit_out = SEED[WIDTH-1]`
  - `valid = 0`
  - `wrap = 0`
  - `lockup = 0`
  - state `INIT`
  - `cnt = 0`
- First cycle with `reset` low: state goes to `RUN`. `valid = 1` from the following cycle; `q` unchanged.
- Step latency: `en` sampled high at edge N produces the new `q` after edge N.
- Load latency: 1 cycle. `valid = 1` after a load edge even when issued in `INIT`.
- Reset asserted mid-run: on the next edge, all reset values are restored; any pending `wrap`/`lockup` is dropped.
- `en` held low: `q`, `cnt`, `valid` hold; `wrap`/`lockup` deassert after their pulse.

## Structure
- Package `lfsr_pkg`:
  - state enum `lfsr_state_t` (`INIT`, `RUN`);
  - default `TAPS`/`SEED` constants for widths 5, 8, 16 (16'hB400, 8'hB8);
  - function `lfsr_fb(q, taps)`.
- Single module, no sub-modules: FSM, step register and counter are small enough to share one file.

## Test plan
- Reset, then `en = 1` from the first `RUN` cycle. Required: `q` = 00010 → 00100 → 01001 → 10010 → 00101 → 01011; `valid = 1`; `bit_out` tracks `q[4]`.
- Continuous `en` for 31 steps. Required: `q` returns to 00010 with `wrap = 1` for exactly that cycle; all 31 non-zero values are seen once; `wrap` repeats after 31 more steps.
- `load = 1`, `load_seed = 5'b11111`, `en = 1` in the same cycle. Required: `q = 11111` next cycle with no step; `cnt` cleared; `wrap` on the 31st subsequent step.
- `load_seed = 0`. Required: `q = 00010`, `lockup` pulses one cycle, `valid = 1`.
- Reset asserted for one cycle mid-sequence with `en` high. Required: `q = 00010`, `valid = 0`, then `RUN`, then stepping resumes from the seed.
- `WIDTH = 8`, `TAPS = 8'hB8`, `SEED = 8'h01`. Required: period 255, `wrap` aligned with `q == 8'h01`; `en` toggling randomly only changes timing, not sequence order.
